// File: rtl/game_state_controller.sv
// -----------------------------------------------------------------------------
// game_state_controller
//
// Per-frame game sequencer. It owns the bird physics (gravity, flap impulse,
// ceiling and ground limits), the score schedule and the game-phase FSM
// (IDLE / PLAYING / DYING / OVER). Everything advances once per frame, on the
// rising edge of the frame-start strobe, so the outputs stay stable for the
// whole frame that the renderer draws.
//
// Ports
//   iClock        in   1   system clock
//   iReset        in   1   synchronous, active-high reset
//   iFrameStart   in   1   frame-start strobe; its rising edge is one tick
//   iFlap         in   1   synchronized flap button (level)
//   oBirdY        out 10   bird top Y, to renderer iBirdY
//   oScore        out 16   current score, to renderer iScore
//   oState        out  2   0=IDLE 1=PLAYING 2=DYING 3=OVER (also the FSM debug view)
//   oScrollEnable out  1   1 in IDLE/PLAYING, 0 in DYING/OVER
//
// Input handshake: there is no valid/ready pair here. A tick is the cycle in
// which iFrameStart is 1 and was 0 on the previous cycle; a flap request is
// latched on any rising edge of iFlap and is consumed or discarded by the next
// tick. All state changes happen on the clock edge that ends the tick cycle.
// -----------------------------------------------------------------------------
module game_state_controller #(
  parameter int BIRD_START_Y      = 228,
  parameter int BIRD_HEIGHT       = 24,
  parameter int GROUND_Y          = 456,
  parameter int GRAVITY           = 1,
  parameter int FLAP_VELOCITY     = 8,
  parameter int MAX_FALL_VELOCITY = 10,
  parameter int SCORE_PERIOD      = 60,
  parameter int SCORE_MAX         = 99,
  parameter int DEATH_FRAMES      = 30
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iFrameStart,
  input  logic        iFlap,
  output logic [9:0]  oBirdY,
  output logic [15:0] oScore,
  output logic [1:0]  oState,
  output logic        oScrollEnable
);

  localparam int Y_MAX = GROUND_Y - BIRD_HEIGHT;
  localparam int FC_W  = (SCORE_PERIOD > 1) ? $clog2(SCORE_PERIOD) : 1;
  localparam int DC_W  = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;

  localparam logic [9:0]         START_Y      = 10'(BIRD_START_Y);
  localparam logic [9:0]         FLAP_Y       = 10'(BIRD_START_Y - FLAP_VELOCITY);
  localparam logic [9:0]         GROUND_TOP   = 10'(Y_MAX);
  localparam logic signed [10:0] GROUND_TOP_S = 11'(Y_MAX);
  localparam logic signed [7:0]  FLAP_V       = 8'(-FLAP_VELOCITY);
  localparam logic signed [7:0]  GRAV_V       = 8'(GRAVITY);
  localparam logic signed [7:0]  MAX_V        = 8'(MAX_FALL_VELOCITY);
  localparam logic [FC_W-1:0]    FC_LAST      = FC_W'(SCORE_PERIOD - 1);
  localparam logic [DC_W-1:0]    DC_LAST      = DC_W'(DEATH_FRAMES - 1);
  localparam logic [15:0]        SCORE_SAT    = 16'(SCORE_MAX);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAYING = 2'd1,
    ST_DYING   = 2'd2,
    ST_OVER    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [9:0]         y_q, y_d;
  logic signed [7:0]  v_q, v_d;
  logic [15:0]        score_q, score_d;
  logic [FC_W-1:0]    fc_q, fc_d;
  logic [DC_W-1:0]    dc_q, dc_d;
  logic               flap_req_q, flap_req_d;
  logic               flap_prev_q, frame_prev_q;
  logic               scroll_q;

  logic               tick, flap_edge, flap_now;
  logic signed [7:0]  v_grav, v_new;
  logic signed [10:0] new_y;

  // Edge detection; a flap edge in the tick cycle itself counts for that tick.
  assign tick      = iFrameStart & ~frame_prev_q;
  assign flap_edge = iFlap & ~flap_prev_q;
  assign flap_now  = flap_req_q | flap_edge;

  // Physics step used in PLAYING: velocity is updated first, then position.
  always_comb begin
    v_grav = v_q + GRAV_V;
    v_new  = flap_now ? FLAP_V : ((v_grav > MAX_V) ? MAX_V : v_grav);
    new_y  = $signed({1'b0, y_q}) + $signed({{3{v_new[7]}}, v_new});
  end

  // State register
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q      <= ST_IDLE;
      y_q          <= START_Y;
      v_q          <= '0;
      score_q      <= '0;
      fc_q         <= '0;
      dc_q         <= '0;
      flap_req_q   <= 1'b0;
      flap_prev_q  <= 1'b0;
      frame_prev_q <= 1'b0;
      scroll_q     <= 1'b1;
    end else begin
      state_q      <= state_d;
      y_q          <= y_d;
      v_q          <= v_d;
      score_q      <= score_d;
      fc_q         <= fc_d;
      dc_q         <= dc_d;
      flap_req_q   <= flap_req_d;
      flap_prev_q  <= iFlap;
      frame_prev_q <= iFrameStart;
      scroll_q     <= (state_d == ST_IDLE) || (state_d == ST_PLAYING);
    end
  end

  // Next-state logic; nothing but the flap latch moves outside a tick.
  always_comb begin
    state_d    = state_q;
    y_d        = y_q;
    v_d        = v_q;
    score_d    = score_q;
    fc_d       = fc_q;
    dc_d       = dc_q;
    flap_req_d = tick ? 1'b0 : (flap_req_q | flap_edge);
    if (tick) begin
      unique case (state_q)
        ST_IDLE: begin
          if (flap_now) begin
            state_d = ST_PLAYING;
            score_d = '0;
            fc_d    = '0;
            v_d     = FLAP_V;
            y_d     = FLAP_Y;
          end
        end
        ST_PLAYING: begin
          v_d = v_new;
          if (new_y[10]) begin
            y_d = '0;
            v_d = '0;
          end else if (new_y >= GROUND_TOP_S) begin
            y_d     = GROUND_TOP;
            v_d     = '0;
            state_d = ST_DYING;
            dc_d    = '0;
          end else begin
            y_d = new_y[9:0];
          end
          // Score still counts on the tick that enters DYING.
          if (fc_q == FC_LAST) begin
            fc_d    = '0;
            score_d = (score_q >= SCORE_SAT) ? SCORE_SAT : score_q + 16'd1;
          end else begin
            fc_d = fc_q + FC_W'(1);
          end
        end
        ST_DYING: begin
          if (dc_q == DC_LAST) state_d = ST_OVER;
          else dc_d = dc_q + DC_W'(1);
        end
        ST_OVER: begin
          // Score is kept for display until the next game starts.
          if (flap_now) begin
            state_d = ST_IDLE;
            y_d     = START_Y;
            v_d     = '0;
          end
        end
      endcase
    end
  end

  // Outputs
  always_comb begin
    oBirdY        = y_q;
    oScore        = score_q;
    oState        = state_q;
    oScrollEnable = scroll_q;
  end

endmodule

// File: tb/tb_game_state_controller.sv
// -----------------------------------------------------------------------------
// tb_game_state_controller
//
// Drives two instances (default parameters, and SCORE_PERIOD=1 for score
// saturation) with the same inputs and checks them against a frame-level
// reference model of the game rules.
// -----------------------------------------------------------------------------
module tb_game_state_controller;

  localparam int START_Y = 228;
  localparam int TOP_Y   = 432;
  localparam int FLAP_V  = 8;
  localparam int MAX_V   = 10;
  localparam int DEATH_N = 30;
  localparam int SMAX    = 99;
  localparam int IDLE = 0, PLAY = 1, DYING = 2, OVER = 3;

  logic        iClock = 1'b0;
  logic        iReset = 1'b1;
  logic        iFrameStart = 1'b0;
  logic        iFlap = 1'b0;
  logic [9:0]  y_a, y_b;
  logic [15:0] score_a, score_b;
  logic [1:0]  state_a, state_b;
  logic        scroll_a, scroll_b;

  int total = 0;
  int bad   = 0;

  // Reference model: index 0 = default instance, index 1 = SCORE_PERIOD=1
  int m_phase[2], m_y[2], m_v[2], m_score[2], m_fc[2], m_dc[2];
  bit m_req[2];
  bit m_prev_flap, m_prev_frame;
  int period[2] = '{60, 1};

  game_state_controller dut_a (
    .iClock(iClock), .iReset(iReset), .iFrameStart(iFrameStart), .iFlap(iFlap),
    .oBirdY(y_a), .oScore(score_a), .oState(state_a), .oScrollEnable(scroll_a)
  );

  game_state_controller #(.SCORE_PERIOD(1)) dut_b (
    .iClock(iClock), .iReset(iReset), .iFrameStart(iFrameStart), .iFlap(iFlap),
    .oBirdY(y_b), .oScore(score_b), .oState(state_b), .oScrollEnable(scroll_b)
  );

  // Clock / reset
  always #5 iClock = ~iClock;

  // One game frame for model instance i
  task automatic model_frame(input int i, input bit fl);
    int ny;
    case (m_phase[i])
      IDLE: if (fl) begin
        m_phase[i] = PLAY; m_score[i] = 0; m_fc[i] = 0;
        m_v[i] = -FLAP_V; m_y[i] = START_Y - FLAP_V;
      end
      PLAY: begin
        m_v[i] = fl ? -FLAP_V : ((m_v[i] + 1 > MAX_V) ? MAX_V : m_v[i] + 1);
        ny = m_y[i] + m_v[i];
        if (ny < 0) begin
          m_y[i] = 0; m_v[i] = 0;
        end else if (ny >= TOP_Y) begin
          m_y[i] = TOP_Y; m_v[i] = 0; m_phase[i] = DYING; m_dc[i] = 0;
        end else m_y[i] = ny;
        m_fc[i]++;
        if (m_fc[i] == period[i]) begin
          m_fc[i] = 0;
          if (m_score[i] < SMAX) m_score[i]++;
        end
      end
      DYING: begin
        m_dc[i]++;
        if (m_dc[i] == DEATH_N) m_phase[i] = OVER;
      end
      default: if (fl) begin
        m_phase[i] = IDLE; m_y[i] = START_Y; m_v[i] = 0;
      end
    endcase
  endtask

  // Applies the inputs seen at one clock edge to the model
  task automatic model_clock();
    bit fe, te;
    if (iReset) begin
      for (int i = 0; i < 2; i++) begin
        m_phase[i] = IDLE; m_y[i] = START_Y; m_v[i] = 0; m_score[i] = 0;
        m_fc[i] = 0; m_dc[i] = 0; m_req[i] = 1'b0;
      end
      m_prev_flap = 1'b0; m_prev_frame = 1'b0;
    end else begin
      fe = iFlap && !m_prev_flap;
      te = iFrameStart && !m_prev_frame;
      for (int i = 0; i < 2; i++) begin
        if (te) begin
          model_frame(i, m_req[i] || fe);
          m_req[i] = 1'b0;
        end else if (fe) m_req[i] = 1'b1;
      end
      m_prev_flap = iFlap; m_prev_frame = iFrameStart;
    end
  endtask

  // Driver tasks
  task automatic step(input bit rst, input bit frame, input bit flap);
    iReset = rst; iFrameStart = frame; iFlap = flap;
    @(posedge iClock);
    model_clock();
    #1;
  endtask

  task automatic do_tick(input bit fl);
    step(1'b0, 1'b1, fl);
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    repeat (3) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    total++; if (y_a !== 10'd228) begin bad++; $display("FAIL reset_y got=%0d exp=228", y_a); end
    total++; if (state_a !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_a); end
    do_tick(1'b1);
    repeat (4) do_tick(1'b0);
    total++; if (state_a !== 2'd1) begin bad++; $display("FAIL pre_reset_playing got=%0d exp=1", state_a); end
    // Reset mid-PLAYING while ticks and flaps are also active
    repeat (3) step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    total++; if (y_a !== 10'd228) begin bad++; $display("FAIL midreset_y got=%0d exp=228", y_a); end
    total++; if (score_a !== 16'd0) begin bad++; $display("FAIL midreset_score got=%0d exp=0", score_a); end
    total++; if (state_a !== 2'd0) begin bad++; $display("FAIL midreset_state got=%0d exp=0", state_a); end
    total++; if (scroll_a !== 1'b1) begin bad++; $display("FAIL midreset_scroll got=%0b exp=1", scroll_a); end
    total++; if (state_b !== 2'd0) begin bad++; $display("FAIL midreset_state_b got=%0d exp=0", state_b); end
    for (int k = 0; k < 3; k++) begin
      do_tick(1'b0);
      total++; if (y_a !== 10'd228 || state_a !== 2'd0) begin
        bad++; $display("FAIL idle_hold y=%0d state=%0d exp y=228 state=0", y_a, state_a);
      end
    end
  endtask

  task automatic test_flap_start();
    int prev_y, max_d;
    bit landed;
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    total++; if (state_a !== 2'd1) begin bad++; $display("FAIL start_state got=%0d exp=1", state_a); end
    total++; if (y_a !== 10'd220) begin bad++; $display("FAIL start_y got=%0d exp=220", y_a); end
    step(1'b0, 1'b0, 1'b0);
    do_tick(1'b0);
    total++; if (y_a !== 10'd213) begin bad++; $display("FAIL fall1_y got=%0d exp=213", y_a); end
    do_tick(1'b0);
    total++; if (y_a !== 10'd207) begin bad++; $display("FAIL fall2_y got=%0d exp=207", y_a); end
    max_d = 0; landed = 1'b0;
    for (int k = 0; k < 100 && !landed; k++) begin
      prev_y = int'(y_a);
      do_tick(1'b0);
      if (int'(y_a) - prev_y > max_d) max_d = int'(y_a) - prev_y;
      total++; if (y_a !== 10'(m_y[0])) begin bad++; $display("FAIL fall_y got=%0d exp=%0d", y_a, m_y[0]); end
      if (state_a != 2'd1) landed = 1'b1;
    end
    total++; if (max_d !== MAX_V) begin bad++; $display("FAIL max_fall_delta got=%0d exp=%0d", max_d, MAX_V); end
    total++; if (y_a !== 10'd432) begin bad++; $display("FAIL ground_y got=%0d exp=432", y_a); end
    total++; if (state_a !== 2'd2) begin bad++; $display("FAIL ground_state got=%0d exp=2", state_a); end
    total++; if (scroll_a !== 1'b0) begin bad++; $display("FAIL ground_scroll got=%0b exp=0", scroll_a); end
  endtask

  // Expects to start on the tick that entered DYING
  task automatic test_dying_over();
    int held_score;
    held_score = m_score[0];
    for (int k = 1; k < DEATH_N; k++) begin
      do_tick(1'b1);
      total++; if (state_a !== 2'd2 || y_a !== 10'd432 || score_a !== 16'(held_score)) begin
        bad++; $display("FAIL dying_hold k=%0d state=%0d y=%0d score=%0d exp 2/432/%0d", k, state_a, y_a, score_a, held_score);
      end
    end
    do_tick(1'b0);
    total++; if (state_a !== 2'd3) begin bad++; $display("FAIL over_state got=%0d exp=3", state_a); end
    do_tick(1'b0);
    total++; if (state_a !== 2'd3 || scroll_a !== 1'b0) begin bad++; $display("FAIL over_hold state=%0d scroll=%0b exp 3/0", state_a, scroll_a); end
    // Flap edge inside the tick cycle itself
    do_tick(1'b1);
    total++; if (state_a !== 2'd0 || y_a !== 10'd228) begin bad++; $display("FAIL restart state=%0d y=%0d exp 0/228", state_a, y_a); end
    total++; if (score_a !== 16'(held_score)) begin bad++; $display("FAIL restart_score got=%0d exp=%0d", score_a, held_score); end
    total++; if (scroll_a !== 1'b1) begin bad++; $display("FAIL restart_scroll got=%0b exp=1", scroll_a); end
  endtask

  task automatic test_score();
    bit landed;
    do_tick(1'b1);
    for (int k = 1; k <= 150; k++) begin
      do_tick(m_y[0] > 240);
      if (k == 59) begin
        total++; if (score_a !== 16'd0) begin bad++; $display("FAIL score_59 got=%0d exp=0", score_a); end
      end
      if (k == 60) begin
        total++; if (score_a !== 16'd1) begin bad++; $display("FAIL score_60 got=%0d exp=1", score_a); end
      end
      if (k == 98) begin
        total++; if (score_b !== 16'd98) begin bad++; $display("FAIL score_b_98 got=%0d exp=98", score_b); end
      end
    end
    total++; if (state_a !== 2'd1) begin bad++; $display("FAIL score_alive got=%0d exp=1", state_a); end
    total++; if (score_a !== 16'd2) begin bad++; $display("FAIL score_150 got=%0d exp=2", score_a); end
    total++; if (score_b !== 16'd99) begin bad++; $display("FAIL score_b_sat got=%0d exp=99", score_b); end
    landed = 1'b0;
    for (int k = 0; k < 200 && !landed; k++) begin
      do_tick(1'b0);
      if (state_a == 2'd2) landed = 1'b1;
    end
    total++; if (!landed) begin bad++; $display("FAIL land_timeout state=%0d exp=2", state_a); end
    repeat (DEATH_N) do_tick(1'b0);
    total++; if (state_a !== 2'd3) begin bad++; $display("FAIL score_over got=%0d exp=3", state_a); end
    do_tick(1'b1);
    total++; if (score_a !== 16'd2 || score_b !== 16'd99) begin
      bad++; $display("FAIL held_score a=%0d b=%0d exp 2/99", score_a, score_b);
    end
    do_tick(1'b1);
    total++; if (state_a !== 2'd1 || score_a !== 16'd0 || score_b !== 16'd0 || y_a !== 10'd220) begin
      bad++; $display("FAIL new_game state=%0d a=%0d b=%0d y=%0d exp 1/0/0/220", state_a, score_a, score_b, y_a);
    end
  endtask

  // Starts in PLAYING at y=220 with v=-8
  task automatic test_ceiling();
    int exp_y[4] = '{12, 4, 0, 0};
    repeat (25) do_tick(1'b1);
    total++; if (y_a !== 10'd20) begin bad++; $display("FAIL ceil_20 got=%0d exp=20", y_a); end
    for (int k = 0; k < 4; k++) begin
      do_tick(1'b1);
      total++; if (y_a !== 10'(exp_y[k]) || state_a !== 2'd1) begin
        bad++; $display("FAIL ceil_y k=%0d got=%0d state=%0d exp=%0d/1", k, y_a, state_a, exp_y[k]);
      end
    end
  endtask

  // Starts clamped at y=0 with v=0
  task automatic test_hold_frame();
    repeat (5) step(1'b0, 1'b1, 1'b0);
    total++; if (y_a !== 10'd1) begin bad++; $display("FAIL hold_frame_y got=%0d exp=1", y_a); end
    step(1'b0, 1'b0, 1'b0);
    do_tick(1'b0);
    total++; if (y_a !== 10'd3) begin bad++; $display("FAIL after_hold_y got=%0d exp=3", y_a); end
  endtask

  task automatic test_random();
    bit rst, fr, fl;
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 499) == 0);
      fr  = ($urandom_range(0, 2) == 0);
      fl  = ($urandom_range(0, 3) == 0);
      step(rst, fr, fl);
      total++; if (y_a !== 10'(m_y[0]) || score_a !== 16'(m_score[0]) || state_a !== 2'(m_phase[0])
                   || scroll_a !== (m_phase[0] <= PLAY)) begin
        bad++; $display("FAIL rand_a c=%0d y=%0d score=%0d state=%0d scroll=%0b exp %0d/%0d/%0d",
                        c, y_a, score_a, state_a, scroll_a, m_y[0], m_score[0], m_phase[0]);
      end
      total++; if (y_b !== 10'(m_y[1]) || score_b !== 16'(m_score[1]) || state_b !== 2'(m_phase[1])
                   || scroll_b !== (m_phase[1] <= PLAY)) begin
        bad++; $display("FAIL rand_b c=%0d y=%0d score=%0d state=%0d exp %0d/%0d/%0d",
                        c, y_b, score_b, state_b, m_y[1], m_score[1], m_phase[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_flap_start();
    test_dying_over();
    test_score();
    test_ceiling();
    test_hold_frame();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
